// File: rtl/clock24_ctrl.sv
// 24-hour BCD clock with debounced MODE/UP buttons and set modes.
// Optional: define AUTO_REPEAT_EN for held-UP auto-repeat in set modes.
module clock24_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE10,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [1:0] MODE,
  output logic       BLINK
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  localparam int BM = 0;
  localparam int BU = 1;

  mode_t       mode;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  lvl;
  logic [1:0]  dcnt [2];
  logic [1:0]  ev;
  logic [6:0]  presc;
  logic [4:0]  bcnt;
  logic [7:0]  hour;
  logic [7:0]  min;
  logic [7:0]  sec;
  logic        blink;
  logic        mode_ev;
  logic        up_ev;
  logic        sec_tick;
  logic [1:0]  btn;

  assign btn = {BTN_UP, BTN_MODE};

  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Sync, then debounce on CE10: 3 equal differing samples flip the level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      lvl     <= 2'b00;
      dcnt[0] <= 2'd0;
      dcnt[1] <= 2'd0;
      ev      <= 2'b00;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      ev    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (CE10) begin
          if (sync2[i] != lvl[i]) begin
            if (dcnt[i] == 2'd2) begin
              lvl[i]  <= sync2[i];
              dcnt[i] <= 2'd0;
              ev[i]   <= sync2[i];
            end else begin
              dcnt[i] <= dcnt[i] + 2'd1;
            end
          end else begin
            dcnt[i] <= 2'd0;
          end
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [5:0] rcnt;
  logic       rep_ev;

  // First repeat 50 CE10 after press, then every 10 while held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt   <= 6'd0;
      rep_ev <= 1'b0;
    end else begin
      rep_ev <= 1'b0;
      if (!lvl[BU] || mode == RUN) begin
        rcnt <= 6'd0;
      end else if (CE10) begin
        if (rcnt == 6'd49) begin
          rcnt   <= 6'd40;
          rep_ev <= 1'b1;
        end else begin
          rcnt <= rcnt + 6'd1;
        end
      end
    end
  end

  assign up_ev = ev[BU] | rep_ev;
`else
  assign up_ev = ev[BU];
`endif

  assign mode_ev  = ev[BM];
  assign sec_tick = CE10 && (mode == RUN) && (presc == 7'd99);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode  <= RUN;
      presc <= 7'd0;
      bcnt  <= 5'd0;
      hour  <= 8'h00;
      min   <= 8'h00;
      sec   <= 8'h00;
      blink <= 1'b1;
    end else begin
      if (mode == RUN && CE10) begin
        presc <= (presc == 7'd99) ? 7'd0 : presc + 7'd1;
      end
      if (sec_tick) begin
        sec <= inc60(sec);
        if (sec == 8'h59) begin
          min <= inc60(min);
          if (min == 8'h59) hour <= inc24(hour);
        end
      end
      unique case (mode)
        RUN: begin
          blink <= 1'b1;
          bcnt  <= 5'd0;
          if (mode_ev) begin
            mode  <= SET_HOUR;
            presc <= 7'd0;
          end
        end
        SET_HOUR, SET_MIN: begin
          presc <= 7'd0;
          if (mode_ev) begin
            blink <= 1'b1;
            bcnt  <= 5'd0;
            if (mode == SET_HOUR) begin
              mode <= SET_MIN;
            end else begin
              mode <= RUN;
              sec  <= 8'h00;
            end
          end else begin
            if (up_ev) begin
              if (mode == SET_HOUR) hour <= inc24(hour);
              else min <= inc60(min);
            end
            if (CE10) begin
              if (bcnt == 5'd24) begin
                bcnt  <= 5'd0;
                blink <= ~blink;
              end else begin
                bcnt <= bcnt + 5'd1;
              end
            end
          end
        end
        default: mode <= RUN;
      endcase
    end
  end

  assign HOUR  = hour;
  assign MIN   = min;
  assign SEC   = sec;
  assign MODE  = mode;
  assign BLINK = blink;

endmodule

// File: tb/tb_clock24_ctrl.sv
// Bench for clock24_ctrl: vector table plus hand sequences.
// Expectations go through a scoreboard queue.
`timescale 1ns/1ps
module tb_clock24_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE10;
  logic       BTN_MODE;
  logic       BTN_UP;
  logic [7:0] HOUR;
  logic [7:0] MIN;
  logic [7:0] SEC;
  logic [1:0] MODE;
  logic       BLINK;

  clock24_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .CE10(CE10),
    .BTN_MODE(BTN_MODE),
    .BTN_UP(BTN_UP),
    .HOUR(HOUR),
    .MIN(MIN),
    .SEC(SEC),
    .MODE(MODE),
    .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] md;
    int         bl;
  } exp_t;

  typedef struct {
    int         mp;
    int         up;
    int         ce;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] md;
    int         bl;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic drain();
    exp_t e;
    bit   ok;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      ok = (HOUR == e.h) && (MIN == e.m) && (SEC == e.s) &&
           (MODE == e.md) && (e.bl < 0 || BLINK == e.bl[0]);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %h:%h:%h mode=%b blink=%b, want %h:%h:%h mode=%b blink=%0d",
                    e.nm, HOUR, MIN, SEC, MODE, BLINK, e.h, e.m, e.s, e.md, e.bl);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] h,
                     input logic [7:0] m, input logic [7:0] s,
                     input logic [1:0] md, input int bl);
    exp_t e;
    e.nm = nm; e.h = h; e.m = m; e.s = s; e.md = md; e.bl = bl;
    sb.push_back(e);
    drain();
  endtask

  task automatic ce(input int n);
    repeat (n) begin
      @(negedge CLK) CE10 = 1'b1;
      @(negedge CLK) CE10 = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge CLK);
  endtask

  task automatic press(input bit m, input bit u);
    BTN_MODE = m;
    BTN_UP   = u;
    settle();
    ce(3);
    BTN_MODE = 1'b0;
    BTN_UP   = 1'b0;
    settle();
    ce(3);
  endtask

  task automatic ups(input int n);
    repeat (n) press(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK) RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 100, 8'h00, 8'h00, 8'h01, 2'b00, 1};
    tbl[1] = '{1, 0, 0,   8'h00, 8'h00, 8'h01, 2'b01, -1};
    tbl[2] = '{0, 1, 0,   8'h01, 8'h00, 8'h01, 2'b01, -1};
    tbl[3] = '{0, 2, 0,   8'h03, 8'h00, 8'h01, 2'b01, -1};
    tbl[4] = '{1, 0, 0,   8'h03, 8'h00, 8'h01, 2'b10, -1};
    tbl[5] = '{0, 1, 0,   8'h03, 8'h01, 8'h01, 2'b10, -1};
    tbl[6] = '{1, 0, 0,   8'h03, 8'h01, 8'h00, 2'b00, 1};
    tbl[7] = '{0, 0, 96,  8'h03, 8'h01, 8'h00, 2'b00, 1};
    tbl[8] = '{0, 0, 1,   8'h03, 8'h01, 8'h01, 2'b00, 1};
    tbl[9] = '{0, 1, 0,   8'h03, 8'h01, 8'h01, 2'b00, 1};

    RST = 1'b1; CE10 = 1'b0; BTN_MODE = 1'b0; BTN_UP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset", 8'h00, 8'h00, 8'h00, 2'b00, 1);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].mp) press(1'b1, 1'b0);
      ups(tbl[i].up);
      ce(tbl[i].ce);
      chk($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s,
          tbl[i].md, tbl[i].bl);
    end

    // Preload 23:59:59 then roll over
    press(1'b1, 1'b0);
    ups(20);
    press(1'b1, 1'b0);
    ups(58);
    press(1'b1, 1'b0);
    ce(97);
    ce(5800);
    chk("at_235959", 8'h23, 8'h59, 8'h59, 2'b00, 1);
    ce(100);
    chk("wrap_midnight", 8'h00, 8'h00, 8'h00, 2'b00, 1);

    // Minute wrap in SET_MIN without hour carry, then resume
    press(1'b1, 1'b0);
    ups(5);
    press(1'b1, 1'b0);
    ups(59);
    chk("min59", 8'h05, 8'h59, 8'h00, 2'b10, -1);
    ups(1);
    chk("min_wrap_nocarry", 8'h05, 8'h00, 8'h00, 2'b10, -1);
    press(1'b1, 1'b0);
    chk("back_to_run", 8'h05, 8'h00, 8'h00, 2'b00, 1);
    ce(96);
    chk("pre_first_sec", 8'h05, 8'h00, 8'h00, 2'b00, 1);
    ce(1);
    chk("first_sec", 8'h05, 8'h00, 8'h01, 2'b00, 1);

    // Glitch rejection and 4-sample press
    do_reset();
    press(1'b1, 1'b0);
    BTN_UP = 1'b1;
    settle();
    ce(2);
    BTN_UP = 1'b0;
    settle();
    ce(3);
    chk("glitch", 8'h00, 8'h00, 8'h00, 2'b01, -1);
    BTN_UP = 1'b1;
    settle();
    ce(4);
    BTN_UP = 1'b0;
    settle();
    ce(3);
    chk("hold4", 8'h01, 8'h00, 8'h00, 2'b01, -1);
    ups(22);
    chk("hour23", 8'h23, 8'h00, 8'h00, 2'b01, -1);
    ups(1);
    chk("hour_wrap", 8'h00, 8'h00, 8'h00, 2'b01, -1);

    // Simultaneous MODE and UP: mode wins
    press(1'b1, 1'b1);
    chk("mode_up_same", 8'h00, 8'h00, 8'h00, 2'b10, -1);

    // Blink: entry=1, toggles after 25 CE10
    ce(21);
    chk("blink_24", 8'h00, 8'h00, 8'h00, 2'b10, 1);
    ce(1);
    chk("blink_25", 8'h00, 8'h00, 8'h00, 2'b10, 0);
    ce(25);
    chk("blink_50", 8'h00, 8'h00, 8'h00, 2'b10, 1);

    // Reset mid-edit discards changes
    ups(2);
    chk("edit_min", 8'h00, 8'h02, 8'h00, 2'b10, -1);
    do_reset();
    chk("reset_mid", 8'h00, 8'h00, 8'h00, 2'b00, 1);

    // Button held across reset release: exactly one event
    @(negedge CLK);
    RST = 1'b1;
    BTN_MODE = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    settle();
    ce(3);
    chk("held_reset_ev", 8'h00, 8'h00, 8'h00, 2'b01, -1);
    ce(10);
    chk("held_no_repeat", 8'h00, 8'h00, 8'h00, 2'b01, -1);
    BTN_MODE = 1'b0;
    settle();
    ce(3);
    chk("release_no_ev", 8'h00, 8'h00, 8'h00, 2'b01, -1);

    // Long UP hold: repeats only with auto-repeat built in
    BTN_UP = 1'b1;
    settle();
    ce(3);
    ce(100);
    BTN_UP = 1'b0;
    settle();
    ce(3);
`ifdef AUTO_REPEAT_EN
    chk("long_hold", 8'h07, 8'h00, 8'h00, 2'b01, -1);
`else
    chk("long_hold", 8'h01, 8'h00, 8'h00, 2'b01, -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
